// File: rtl/mem_debug_dumper_pkg.sv
// Shared types and sizing helpers for the data-memory debug dumper.
package mem_debug_pkg;

  // Controller states: wait for request, present address, stream bytes, completion pulse.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

  // Default geometry: 16 words of 32 bits, streamed as bytes.
  localparam int DEF_NB      = 32;
  localparam int DEF_TAM     = 16;
  localparam int DEF_NB_BYTE = 8;

  // Number of stream bytes that make up one memory word (BYTES_PER_WORD).
  function automatic int bytes_per_word(input int nb, input int nb_byte);
    return nb / nb_byte;
  endfunction

  // Counter width able to index n items; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_debug_dumper_word_serializer.sv
// Turns one captured memory word into a MSB-byte-first valid/ready byte stream.
module word_serializer
  import mem_debug_pkg::*;
#(
  parameter int NB      = DEF_NB,
  parameter int NB_BYTE = DEF_NB_BYTE
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB-1:0]      i_word,
  input  logic               i_tx_ready,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_last_xfer
);

  localparam int BPW = bytes_per_word(NB, NB_BYTE);
  localparam int BCW = cnt_width(BPW);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

  logic [NB-1:0]  shift_reg;
  logic [BCW-1:0] byte_cnt_reg;
  logic           valid_reg;
  logic           xfer;
  logic           last_byte;

  assign xfer        = valid_reg & i_tx_ready;
  assign last_byte   = (byte_cnt_reg == LAST_BYTE);
  // Tells the controller that the final byte of the word leaves at this edge.
  assign o_last_xfer = xfer & last_byte;

  // The stream byte is always the top slice of the shift register, so it cannot
  // change while the sink stalls.
  assign o_tx_data   = shift_reg[NB-1 -: NB_BYTE];
  assign o_tx_valid  = valid_reg;

  // Load a word, then shift one byte out per accepted transfer; valid drops only
  // after the last byte has been taken.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
      valid_reg    <= 1'b0;
    end else if (i_load) begin
      shift_reg    <= i_word;
      byte_cnt_reg <= '0;
      valid_reg    <= 1'b1;
    end else if (xfer) begin
      shift_reg <= shift_reg << NB_BYTE;
      if (last_byte) begin
        byte_cnt_reg <= '0;
        valid_reg    <= 1'b0;
      end else begin
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_debug_dumper.sv
// Sequences a full read-out of data memory through the debug read port and
// streams every word MSB-byte-first toward the debug UART transmitter.
module mem_debug_dumper
  import mem_debug_pkg::*;
#(
  parameter int NB      = DEF_NB,
  parameter int TAM     = DEF_TAM,
  parameter int NB_BYTE = DEF_NB_BYTE
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_halted,
  output logic [NB-1:0]      o_debug_address,
  input  logic [NB-1:0]      i_debug_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int WCW = cnt_width(TAM);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(TAM - 1);

  dump_state_e    state_reg;
  logic [WCW-1:0] word_cnt_reg;
  logic [WCW-1:0] word_cnt_next;
  logic [NB-1:0]  addr_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           load;
  logic           last_xfer;

  // The memory read is combinational, so the word is valid during the ADDR cycle
  // and captured at its closing edge.
  assign load          = (state_reg == ST_ADDR);
  assign word_cnt_next = word_cnt_reg + 1'b1;

  assign o_debug_address = addr_reg;
  assign o_busy          = busy_reg;
  assign o_done          = done_reg;

  // Controller FSM with word counter and registered address/status outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg    <= ST_IDLE;
      word_cnt_reg <= '0;
      addr_reg     <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // A request only counts while the pipeline is halted; the address
          // restarts from word 0 on every accepted dump.
          if (i_start && i_halted) begin
            state_reg    <= ST_ADDR;
            word_cnt_reg <= '0;
            addr_reg     <= '0;
            busy_reg     <= 1'b1;
          end
        end
        ST_ADDR: begin
          state_reg <= ST_SEND;
        end
        ST_SEND: begin
          if (last_xfer) begin
            if (word_cnt_reg == LAST_WORD) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg    <= ST_ADDR;
              word_cnt_reg <= word_cnt_next;
              addr_reg     <= NB'(word_cnt_next);
            end
          end
        end
        ST_DONE: begin
          // Address keeps the last word index until the next start or reset.
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  word_serializer #(
    .NB      (NB),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (load),
    .i_word      (i_debug_data),
    .i_tx_ready  (i_tx_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .o_last_xfer (last_xfer)
  );

endmodule

// File: tb/tb_mem_debug_dumper.sv
// Self-checking bench for mem_debug_dumper: vector table for reset/start gating,
// byte scoreboard for the streamed dumps, and hand sequences for corner cases.
module tb_mem_debug_dumper;

  logic        clk;
  logic        rst_n;

  // Default-geometry instance (32-bit words, 16 words)
  logic        start0, halted0, ready0;
  logic [31:0] addr0, data0;
  logic [7:0]  txd0;
  logic        valid0, busy0, done0;

  // Single-word instance
  logic        start1, ready1;
  logic [31:0] addr1, data1;
  logic [7:0]  txd1;
  logic        valid1, busy1, done1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bytes_seen = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [7:0] exp_q[$];

  logic       pend_stall = 1'b0;
  logic [7:0] stall_data = 8'h00;

  mem_debug_dumper #(.NB(32), .TAM(16), .NB_BYTE(8)) dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_start         (start0),
    .i_halted        (halted0),
    .o_debug_address (addr0),
    .i_debug_data    (data0),
    .o_tx_data       (txd0),
    .o_tx_valid      (valid0),
    .i_tx_ready      (ready0),
    .o_busy          (busy0),
    .o_done          (done0)
  );

  mem_debug_dumper #(.NB(32), .TAM(1), .NB_BYTE(8)) dut_one (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_start         (start1),
    .i_halted        (1'b1),
    .o_debug_address (addr1),
    .i_debug_data    (data1),
    .o_tx_data       (txd1),
    .o_tx_valid      (valid1),
    .i_tx_ready      (ready1),
    .o_busy          (busy1),
    .o_done          (done1)
  );

  // Memory models: word k = A0B0C000+k; single-word memory holds DEADBEEF at 0.
  assign data0 = 32'hA0B0C000 + addr0;
  assign data1 = (addr1 == 32'h0) ? 32'hDEADBEEF : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push_dump();
    logic [31:0] w;
    for (int k = 0; k < 16; k++) begin
      w = 32'hA0B0C000 + k;
      for (int b = 0; b < 4; b++) exp_q.push_back(w[31-8*b -: 8]);
    end
  endtask

  task automatic wait_done(input int bound, input int d0, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL %s: got=no o_done expected=o_done within %0d cycles", name, bound);
    end
  endtask

  // Stream monitor: inputs change just after the rising edge, so values seen at
  // the falling edge are exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_stall = 1'b0;
    end else begin
      if (pend_stall) begin
        check("stall_valid_held", {31'b0, valid0}, 32'h1);
        check("stall_data_held", {24'b0, txd0}, {24'b0, stall_data});
      end
      if (valid0 && ready0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got=%0h expected=no byte", txd0);
        end else begin
          check("stream_byte", {24'b0, txd0}, {24'b0, exp_q.pop_front()});
        end
        bytes_seen++;
      end
      pend_stall = valid0 && !ready0;
      stall_data = txd0;
      if (done0) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       halted;
    logic       ready;
    logic       kick;
    logic       busy;
    logic       valid;
    logic       done;
    logic [7:0] data;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int start_cyc;
    int b0, d0;
    logic [7:0] exp1[4];
    int bytes1, done1_cnt, done1_idx;

    // rst start halt rdy kick | busy valid done data addr
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA0, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0};

    rst_n = 1'b0; start0 = 1'b0; halted0 = 1'b0; ready0 = 1'b1;
    start1 = 1'b0; ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset/idle and start gating table
    for (int i = 0; i < 9; i++) begin
      rst_n = vecs[i].rst_n; start0 = vecs[i].start;
      halted0 = vecs[i].halted; ready0 = vecs[i].ready;
      if (vecs[i].kick) push_dump();
      @(posedge clk); #1;
      check($sformatf("vec%0d_busy", i), {31'b0, busy0}, {31'b0, vecs[i].busy});
      check($sformatf("vec%0d_valid", i), {31'b0, valid0}, {31'b0, vecs[i].valid});
      check($sformatf("vec%0d_done", i), {31'b0, done0}, {31'b0, vecs[i].done});
      check($sformatf("vec%0d_data", i), {24'b0, txd0}, {24'b0, vecs[i].data});
      check($sformatf("vec%0d_addr", i), addr0, vecs[i].addr);
      $display("vector %0d: busy=%0b valid=%0b data=%0h", i, busy0, valid0, txd0);
    end
    exp_q.delete();
    start0 = 1'b0; ready0 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full dump with sink always ready
    b0 = bytes_seen; d0 = done_cnt;
    push_dump();
    start0 = 1'b1; halted0 = 1'b1;
    @(posedge clk);
    start_cyc = cyc + 1;
    #1;
    start0 = 1'b0;
    check("full_addr_cycle_busy", {31'b0, busy0}, 32'h1);
    check("full_addr_cycle_valid", {31'b0, valid0}, 32'h0);
    @(posedge clk); #1;
    check("full_first_valid", {31'b0, valid0}, 32'h1);
    check("full_first_data", {24'b0, txd0}, 32'hA0);
    wait_done(200, d0, "full_timeout");
    // o_done occupies the 81st cycle counted from the start-sampling edge
    check("full_done_latency", done_cyc - start_cyc, 32'd80);
    check("full_byte_count", bytes_seen - b0, 32'd64);
    check("full_done_count", done_cnt - d0, 32'd1);
    check("full_queue_empty", exp_q.size(), 32'd0);
    check("full_last_addr", addr0, 32'd15);
    @(posedge clk); #1;
    check("full_idle_busy", {31'b0, busy0}, 32'h0);
    $display("full dump: bytes=%0d done_latency=%0d", bytes_seen - b0, done_cyc - start_cyc);

    // Random backpressure, halt dropped after start, extra start mid-dump
    b0 = bytes_seen; d0 = done_cnt;
    push_dump();
    start0 = 1'b1; halted0 = 1'b1;
    for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
      @(posedge clk); #1;
      start0  = (c == 40);
      halted0 = (c == 40);
      ready0  = ($urandom_range(0, 9) < 3);
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL bp_timeout: got=no o_done expected=o_done within 3000 cycles");
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      ready0 = ($urandom_range(0, 9) < 3);
    end
    ready0 = 1'b1;
    check("bp_byte_count", bytes_seen - b0, 32'd64);
    check("bp_done_count", done_cnt - d0, 32'd1);
    check("bp_queue_empty", exp_q.size(), 32'd0);
    check("bp_idle_busy", {31'b0, busy0}, 32'h0);
    $display("backpressure dump: bytes=%0d dones=%0d", bytes_seen - b0, done_cnt - d0);

    // Reset in SEND of word 5, byte 2
    b0 = bytes_seen; d0 = done_cnt;
    push_dump();
    start0 = 1'b1; halted0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int c = 0; c < 200 && (bytes_seen - b0) != 22; c++) begin
      @(posedge clk); #1;
    end
    check("rst_pre_bytes", bytes_seen - b0, 32'd22);
    check("rst_pre_addr", addr0, 32'd5);
    check("rst_pre_data", {24'b0, txd0}, 32'hC0);
    rst_n = 1'b0;
    #1;
    check("rst_async_busy", {31'b0, busy0}, 32'h0);
    check("rst_async_valid", {31'b0, valid0}, 32'h0);
    check("rst_async_data", {24'b0, txd0}, 32'h0);
    check("rst_async_addr", addr0, 32'h0);
    check("rst_async_done", {31'b0, done0}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_done", done_cnt - d0, 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    b0 = bytes_seen; d0 = done_cnt;
    push_dump();
    start0 = 1'b1; halted0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done(200, d0, "rst_restart_timeout");
    check("rst_restart_bytes", bytes_seen - b0, 32'd64);
    check("rst_restart_done", done_cnt - d0, 32'd1);
    $display("reset restart dump: bytes=%0d", bytes_seen - b0);

    // Single-word instance: DE AD BE EF then o_done, address pinned at 0
    exp1[0] = 8'hDE; exp1[1] = 8'hAD; exp1[2] = 8'hBE; exp1[3] = 8'hEF;
    bytes1 = 0; done1_cnt = 0; done1_idx = -1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("tam1_addr", addr1, 32'h0);
      if (valid1) begin
        if (bytes1 < 4) check("tam1_byte", {24'b0, txd1}, {24'b0, exp1[bytes1]});
        else begin
          checks++;
          errors++;
          $display("FAIL tam1_extra_byte: got=%0h expected=no byte", txd1);
        end
        bytes1++;
      end
      if (done1) begin
        done1_cnt++;
        done1_idx = c;
      end
    end
    check("tam1_byte_count", bytes1, 32'd4);
    check("tam1_done_count", done1_cnt, 32'd1);
    check("tam1_done_cycle", done1_idx, 32'd5);
    check("tam1_idle_busy", {31'b0, busy1}, 32'h0);
    $display("single word dump: bytes=%0d done_cycle=%0d", bytes1, done1_idx);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_debug_dumper.md
Name: mem_debug_dumper

Overview:
- Controller that sequences a full read-out of the data memory through the MEMORY stage debug read port. Used while the pipeline is halted.
- Walks the debug address from word 0 to TAM-1 and captures each word.
- Serialises each word MSB-byte-first onto a byte-wide valid/ready stream toward the debug UART transmitter.
- Sits in the debug unit, between the debug command decoder and the UART TX FIFO.

Parameters:
- NB, 32: data and debug-address width; must be a multiple of 8.
- TAM, 16: number of memory words to dump; must be >= 1.
- NB_BYTE, 8: stream byte width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  dump request; sampled only in IDLE.
- i_halted  in  1  pipeline halted; i_start is accepted only when this is 1.
- o_debug_address  out  NB  word index driven to the memory debug read port.
- i_debug_data  in  NB  memory debug read data for o_debug_address (combinational read).
- o_tx_data  out  NB_BYTE  byte on the stream.
- o_tx_valid  out  1  byte valid.
- i_tx_ready  in  1  sink ready.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  single-cycle pulse when the dump completes.

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE; all outputs 0; word counter and byte counter cleared.
- States: IDLE, ADDR, SEND, DONE. Encoding is defined in the package.
- IDLE:
  - i_start=1 and i_halted=1 at an edge -> ADDR, word counter=0.
  - Otherwise stay in IDLE.
- ADDR (exactly 1 cycle):
  - o_debug_address = word counter, zero-extended to NB.
  - At the closing edge, capture i_debug_data into the shift register, clear the byte counter, go to SEND.
- SEND:
  - o_tx_valid=1; o_tx_data = byte [NB-1 -: 8] of the current shift value.
  - A transfer happens at an edge where o_tx_valid & i_tx_ready = 1. On a transfer: shift left by 8, increment the byte counter.
  - Without i_tx_ready, o_tx_data and o_tx_valid stay stable; valid is never retracted.
  - After transfer of byte NB/8-1:
    - If word counter == TAM-1 -> DONE.
    - Else word counter +1 and go to ADDR.
  - o_tx_valid is 0 during the ADDR gap, giving 1 bubble per word.
- DONE (1 cycle): o_done=1, o_busy=1, o_tx_valid=0 -> IDLE.
- o_debug_address holds its last value outside ADDR. It returns to 0 only at reset or at the next start.
- Timing with i_tx_ready tied to 1:
  - Per word: 1 ADDR cycle + NB/8 SEND cycles.
  - Full dump: TAM*(1+NB/8) cycles, then 1 DONE cycle. Defaults give 80 + 1 cycles.
  - The first byte is valid 2 cycles after the edge that samples i_start.
- i_start while busy is ignored; no queuing.
- i_halted is ignored once the dump has started. The upstream debug controller holds the halt.
- Word counter width is clog2(TAM), minimum 1 bit. Byte counter width is clog2(NB/8).
- Reset asserted mid-dump: immediate return to IDLE with all outputs 0. No o_done pulse. A partially sent word is discarded.

Decomposition:
- Package mem_debug_pkg holds:
  - state enum constants (IDLE, ADDR, SEND, DONE);
  - BYTES_PER_WORD = NB/8;
  - clog2-derived counter widths.
- One natural sub-module: word_serializer.
  - Contents: shift register, byte counter, valid/ready output stage.
  - Interface: load strobe and last-byte flag exchanged with the FSM.
- The FSM and word counter stay in mem_debug_dumper.

Test Plan:
- Reset/idle: hold i_reset=0, toggle i_start -> all outputs 0. Release reset with i_start=0 -> o_busy stays 0.
- Full dump, ready=1: memory word k = 0xA0B0C000+k, pulse i_start with i_halted=1.
  - Expected stream: A0,B0,C0,00,A0,B0,C0,01, ... through ...,C0,0F.
  - Exactly 64 bytes; o_done pulses once, 81 cycles after the start edge.
- Backpressure: i_tx_ready random (about 30% duty).
  - No byte lost or duplicated.
  - o_tx_data stable while valid&!ready.
  - o_tx_valid never falls without a transfer.
- Start gating:
  - i_start with i_halted=0 -> stays IDLE.
  - i_start pulsed mid-dump -> ignored; only one o_done; byte count still 64.
- Reset mid-operation: assert i_reset during SEND of word 5, byte 2.
  - Outputs 0 in the same cycle (asynchronous); no o_done.
  - A new start then streams from word 0.
- Boundary: instantiate with TAM=1 and word 0 = 0xDEADBEEF -> stream DE,AD,BE,EF, then o_done; o_debug_address stays 0 throughout.
